// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the memory FSM encoding, the control bundle and the load-use helper.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_flush;
        logic mem_stall;
        logic memwb_bubble;
    } hz_ctrl_t;

    // Free-running pipeline: PC advances, nothing is held, flushed or bubbled.
    localparam hz_ctrl_t HZ_IDLE = '{
        pc_write:     1'b1,
        ifid_stall:   1'b0,
        ifid_flush:   1'b0,
        idex_flush:   1'b0,
        mem_stall:    1'b0,
        memwb_bubble: 1'b0
    };

    function automatic logic load_use(
        input logic             memread,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2
    );
        return memread && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Request/acknowledge handshake between the hazard controller and the data cache.
interface pipeline_hazard_ctrl_if;

    logic mem_req_o;
    logic mem_ack_i;

    modport master (output mem_req_o, input  mem_ack_i);
    modport slave  (input  mem_req_o, output mem_ack_i);

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_access_fsm.sv
// Data-memory access sequencer: one request per EX/MEM memory instruction,
// a wait-cycle watchdog with sticky error, and the combinational memory stall.
module pipeline_hazard_ctrl_mem_access_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic memop_i,
    input  logic mem_ack_i,
    output logic mem_req_o,
    output logic mem_stall_o,
    output logic err_o
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= M_IDLE;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    // Ack is only looked at in M_WAIT; the watchdog saturates at TIMEOUT.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        err_d   = err_q;
        wait_d  = wait_q;
        unique case (state_q)
            M_IDLE: begin
                if (start_i && memop_i) begin
                    state_d = M_WAIT;
                    req_d   = 1'b1;
                    wait_d  = '0;
                end
            end
            M_WAIT: begin
                if (mem_ack_i) begin
                    state_d = M_DONE;
                    req_d   = 1'b0;
                end else if (wait_q != WAIT_W'(TIMEOUT)) begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_W'(TIMEOUT)) begin
                        err_d = 1'b1;
                    end
                end
            end
            M_DONE: begin
                state_d = M_IDLE;
            end
            default: begin
                state_d = M_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign mem_req_o   = req_q;
    assign err_o       = err_q;
    assign mem_stall_o = !rst_i &&
                         (((state_q == M_IDLE) && start_i && memop_i) || (state_q == M_WAIT));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory stalls,
// load-use bubbles and taken-branch flushes, plus a memory-stall cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  idex_memread_i,
    input  logic [REG_W-1:0]      idex_rd_i,
    input  logic [REG_W-1:0]      ifid_rs1_i,
    input  logic [REG_W-1:0]      ifid_rs2_i,
    input  logic                  branch_taken_i,
    input  logic                  exmem_memread_i,
    input  logic                  exmem_memwrite_i,
    pipeline_hazard_ctrl_if.master mem_if,
    output logic                  mem_stall_o,
    output logic                  memwb_bubble_o,
    output logic                  pc_write_o,
    output logic                  ifid_stall_o,
    output logic                  ifid_flush_o,
    output logic                  idex_flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  err_o
);

    logic             memop;
    logic             mem_stall;
    logic             mem_req;
    logic             lu;
    hz_ctrl_t         ctrl;
    logic [CNT_W-1:0] stall_cnt_q;

    assign memop = exmem_memread_i | exmem_memwrite_i;
    assign lu    = load_use(idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i);

    pipeline_hazard_ctrl_mem_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_access_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .memop_i     (memop),
        .mem_ack_i   (mem_if.mem_ack_i),
        .mem_req_o   (mem_req),
        .mem_stall_o (mem_stall),
        .err_o       (err_o)
    );

    assign mem_if.mem_req_o = mem_req;

    // Memory stall dominates load-use, which dominates a taken branch.
    always_comb begin
        ctrl = HZ_IDLE;
        if (!rst_i) begin
            if (mem_stall) begin
                ctrl.pc_write     = 1'b0;
                ctrl.ifid_stall   = 1'b1;
                ctrl.mem_stall    = 1'b1;
                ctrl.memwb_bubble = 1'b1;
            end else if (lu) begin
                ctrl.pc_write   = 1'b0;
                ctrl.ifid_stall = 1'b1;
                ctrl.idex_flush = 1'b1;
            end else if (branch_taken_i) begin
                ctrl.ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (ctrl.mem_stall) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign mem_stall_o    = ctrl.mem_stall;
    assign memwb_bubble_o = ctrl.memwb_bubble;
    assign pc_write_o     = ctrl.pc_write;
    assign ifid_stall_o   = ctrl.ifid_stall;
    assign ifid_flush_o   = ctrl.ifid_flush;
    assign idex_flush_o   = ctrl.idex_flush;
    assign stall_cnt_o    = stall_cnt_q;

endmodule
